uart_receiver: RTL and testbench

- Serial-to-parallel receiver for the 7-bit UART link; counterpart of the `sender` transmitter.
- Frame format: start bit (0), 7 data bits LSB first, even-parity bit, stop bit (1). Baud rate and clock period match the transmitter.
- Samples the asynchronous line at mid-bit and presents each byte with a one-cycle valid strobe and error flags.
- Sits between the board RX pin and the consumer logic.

---
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 7-bit UART receiver: start, 7 data bits LSB first, even parity, stop; mid-bit sampling.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_receiver #(
  parameter int bowd_rate  = 9600,
  parameter int clk_pariod = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_serial_bit,
  output logic [6:0] recv_data,
  output logic       recv_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CLKS  = (1000000000 / bowd_rate) / clk_pariod;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CLKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [1:0]  sync_q, sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [1:0]  settle_q, settle_d;
  logic [6:0]  recv_data_q, recv_data_d;
  logic        recv_valid_q, recv_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  logic rx_s, fall, sampling, at_target, decide, bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  logic       pend_q, pend_d;
`endif

  assign rx_s = sync_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    recv_data_d  = recv_data_q;
    recv_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    sync_d       = {sync_q[0], in_serial_bit};
    rx_prev_d    = rx_s;
    settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

    // Edge detect is armed only once the synchronizer holds real line values,
    // so a line already low at reset release is not mistaken for a start bit.
    fall      = (settle_q == 2'd3) && rx_prev_q && !rx_s;
    sampling  = (state_q == START) || (state_q == DATA) ||
                (state_q == PARITY) || (state_q == STOP);
    at_target = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);

    if (sampling) cnt_d = at_target ? 16'd0 : cnt_q + 16'd1;

`ifdef UART_RX_MAJORITY_EN
    hist_d  = {hist_q[0], rx_s};
    pend_d  = sampling && at_target;
    decide  = pend_q && sampling;
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    decide  = sampling && at_target;
    bit_val = rx_s;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (fall) state_d = START;
      end
      START: if (decide) begin
        if (bit_val) state_d = IDLE;
        else begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: if (decide) begin
        shift_d = {bit_val, shift_q[6:1]};
        if (idx_q == 3'd6) state_d = PARITY;
        else               idx_d   = idx_q + 3'd1;
      end
      PARITY: if (decide) begin
        parity_d = bit_val;
        state_d  = STOP;
      end
      STOP: if (decide) begin
        recv_valid_d = 1'b1;
        recv_data_d  = shift_q;
        parity_err_d = ^{shift_q, parity_q};
        frame_err_d  = !bit_val;
        state_d      = bit_val ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d = 16'd0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      settle_q     <= '0;
      recv_data_q  <= '0;
      recv_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      sync_q       <= sync_d;
      rx_prev_q    <= rx_prev_d;
      settle_q     <= settle_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
      pend_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pend_q <= pend_d;
    end
  end
`endif

  assign recv_data  = recv_data_q;
  assign recv_valid = recv_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver; a fast baud setting gives 20 clocks per bit.
module tb_uart_receiver;

  localparam int BAUD = 1000000;
  localparam int CLKP = 50;
  localparam int BIT  = (1000000000 / BAUD) / CLKP;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic [6:0] recv_data;
  logic       recv_valid, parity_err, frame_err, busy;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int v_cnt   = 0;
  logic [6:0] cap_data [0:15];
  logic       cap_perr [0:15];
  logic       cap_ferr [0:15];

  always #5 clk = ~clk;

  uart_receiver #(.bowd_rate(BAUD), .clk_pariod(CLKP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_serial_bit (line),
    .recv_data     (recv_data),
    .recv_valid    (recv_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always @(negedge clk) begin
    if (recv_valid === 1'b1) begin
      if (v_cnt < 16) begin
        cap_data[v_cnt] = recv_data;
        cap_perr[v_cnt] = parity_err;
        cap_ferr[v_cnt] = frame_err;
      end
      v_cnt = v_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    line = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
    bit_time(1'b0);
    for (int i = 0; i < 7; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
  endtask

  initial begin
    line = 1'b1;
    rst  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", recv_valid, 0);
    check("rst_data",  recv_data,  0);
    check("rst_perr",  parity_err, 0);
    check("rst_ferr",  frame_err,  0);
    check("rst_busy",  busy,       0);

    repeat (2000) @(negedge clk);
    check("idle_pulses", v_cnt,     0);
    check("idle_busy",   busy,      0);
    check("idle_data",   recv_data, 0);
    check("idle_ferr",   frame_err, 0);

    send_frame(7'h55, 1'b0, 1'b1);
    check("f55_pulses", v_cnt,       1);
    check("f55_data",   cap_data[0], 7'h55);
    check("f55_perr",   cap_perr[0], 0);
    check("f55_ferr",   cap_ferr[0], 0);
    check("f55_strobe", recv_valid,  0);
    check("f55_busy",   busy,        0);

    send_frame(7'h07, 1'b0, 1'b1);
    check("f07_pulses", v_cnt,       2);
    check("f07_data",   cap_data[1], 7'h07);
    check("f07_perr",   cap_perr[1], 1);
    check("f07_ferr",   cap_ferr[1], 0);

    send_frame(7'h7F, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    check("f7f_pulses",   v_cnt,       3);
    check("f7f_data",     cap_data[2], 7'h7F);
    check("f7f_perr",     cap_perr[2], 0);
    check("f7f_ferr",     cap_ferr[2], 1);
    check("f7f_waithigh", busy,        1);
    line = 1'b1;
    repeat (10) @(negedge clk);
    check("f7f_released", busy,  0);
    check("f7f_no_retrig", v_cnt, 3);
    repeat (2 * BIT) @(negedge clk);

    line = 1'b0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    check("glitch_start", busy, 1);
    repeat (20) @(negedge clk);
    check("glitch_idle",   busy,      0);
    check("glitch_pulses", v_cnt,     3);
    check("glitch_hold_d", recv_data, 7'h7F);
    check("glitch_hold_f", frame_err, 1);

    send_frame(7'h01, 1'b1, 1'b1);
    send_frame(7'h40, 1'b1, 1'b1);
    check("b2b_pulses", v_cnt,       5);
    check("b2b_data0",  cap_data[3], 7'h01);
    check("b2b_data1",  cap_data[4], 7'h40);
    check("b2b_perr1",  cap_perr[4], 0);
    check("b2b_ferr1",  cap_ferr[4], 0);

    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_data", recv_data,  0);
    check("abort_perr", parity_err, 0);
    check("abort_ferr", frame_err,  0);
    check("abort_busy", busy,       0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("low_at_release", busy, 0);
    line = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("abort_pulses", v_cnt,      5);
    check("abort_valid",  recv_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
